// File: rtl/box_locator.sv
// box_locator: zero-latency pixel pass-through that reports the bounding box of
// skin-coloured pixels in each frame, latched at end of frame.
module box_locator #(
  parameter int          IMG_W      = 640,
  parameter int          IMG_H      = 480,
  parameter logic [7:0]  R_MIN      = 8'd96,
  parameter logic [18:0] MIN_PIXELS = 19'd64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_sync,
  input  logic        in_empty,
  input  logic [23:0] in_dout,
  output logic        in_rd_en,
  input  logic        out_full,
  output logic        out_wr_en,
  output logic [23:0] out_din,
  output logic [9:0]  box_x,
  output logic [9:0]  box_y,
  output logic [9:0]  box_w,
  output logic [9:0]  box_h,
  output logic        box_found,
  output logic        box_valid
);
  localparam logic [9:0] LAST_X = 10'(IMG_W - 1);
  localparam logic [9:0] LAST_Y = 10'(IMG_H - 1);
  logic        xfer, match, eof, found;
  logic [7:0]  r, g, b;
  logic [9:0]  col_q, row_q, col_d, row_d, px, py;
  logic [9:0]  min_x_q, min_y_q, max_x_q, max_y_q;
  logic [9:0]  min_x_b, min_y_b, max_x_b, max_y_b;
  logic [9:0]  min_x_n, min_y_n, max_x_n, max_y_n;
  logic [18:0] hit_q, hit_b, hit_n;
  logic [9:0]  box_x_q, box_y_q, box_w_q, box_h_q;
  logic        box_found_q, box_valid_q;
  assign r         = in_dout[23:16];
  assign g         = in_dout[15:8];
  assign b         = in_dout[7:0];
  assign xfer      = reset && !in_empty && !out_full;
  assign in_rd_en  = xfer;
  assign out_wr_en = xfer;
  assign out_din   = in_dout;
  assign match     = xfer && r >= R_MIN && r > g && r > b;
  assign box_x     = box_x_q;
  assign box_y     = box_y_q;
  assign box_w     = box_w_q;
  assign box_h     = box_h_q;
  assign box_found = box_found_q;
  assign box_valid = box_valid_q;
  // frame_sync rebases position and accumulators before this cycle's pixel is applied
  always_comb begin
    px      = frame_sync ? '0 : col_q;
    py      = frame_sync ? '0 : row_q;
    min_x_b = frame_sync ? 10'h3FF : min_x_q;
    min_y_b = frame_sync ? 10'h3FF : min_y_q;
    max_x_b = frame_sync ? '0 : max_x_q;
    max_y_b = frame_sync ? '0 : max_y_q;
    hit_b   = frame_sync ? '0 : hit_q;
    min_x_n = match && px < min_x_b ? px : min_x_b;
    min_y_n = match && py < min_y_b ? py : min_y_b;
    max_x_n = match && px > max_x_b ? px : max_x_b;
    max_y_n = match && py > max_y_b ? py : max_y_b;
    hit_n   = match && hit_b != '1 ? hit_b + 19'd1 : hit_b;
    found   = hit_n >= MIN_PIXELS;
    eof     = xfer && !frame_sync && px == LAST_X && py == LAST_Y;
    col_d   = !xfer ? px : px == LAST_X ? '0 : px + 10'd1;
    row_d   = !xfer || px != LAST_X ? py : py == LAST_Y ? '0 : py + 10'd1;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      col_q       <= '0;
      row_q       <= '0;
      min_x_q     <= 10'h3FF;
      min_y_q     <= 10'h3FF;
      max_x_q     <= '0;
      max_y_q     <= '0;
      hit_q       <= '0;
      box_x_q     <= '0;
      box_y_q     <= '0;
      box_w_q     <= '0;
      box_h_q     <= '0;
      box_found_q <= 1'b0;
      box_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      min_x_q     <= eof ? 10'h3FF : min_x_n;
      min_y_q     <= eof ? 10'h3FF : min_y_n;
      max_x_q     <= eof ? '0 : max_x_n;
      max_y_q     <= eof ? '0 : max_y_n;
      hit_q       <= eof ? '0 : hit_n;
      box_valid_q <= eof;
      if (eof) begin
        box_x_q     <= found ? min_x_n : '0;
        box_y_q     <= found ? min_y_n : '0;
        box_w_q     <= found ? max_x_n - min_x_n + 10'd1 : '0;
        box_h_q     <= found ? max_y_n - min_y_n + 10'd1 : '0;
        box_found_q <= found;
      end
    end
  end
endmodule

// File: tb/tb_box_locator.sv
// tb_box_locator: table-driven frames plus stall/sync/reset sequences, with a
// pixel scoreboard and a box-result scoreboard checked at each box_valid.
module tb_box_locator;
  typedef struct packed {
    logic [9:0] x, y, w, h; logic f;
    logic [9:0] x1, y1, w1, h1; logic f1;
  } exp_t;
  typedef struct packed {
    logic [23:0] c;
    logic [47:0] m;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0, frame_sync = 1'b0, in_empty = 1'b1, out_full = 1'b0;
  logic [23:0] in_dout = '0;
  logic        in_rd_en, out_wr_en, box_found, box_valid;
  logic [23:0] out_din;
  logic [9:0]  box_x, box_y, box_w, box_h;
  logic        in_rd_en1, out_wr_en1, box_found1, box_valid1;
  logic [23:0] out_din1;
  logic [9:0]  box_x1, box_y1, box_w1, box_h1;

  box_locator #(.IMG_W(8), .IMG_H(6), .R_MIN(8'd96), .MIN_PIXELS(19'd2)) dut (
    .clock(clk), .reset(reset), .frame_sync(frame_sync), .in_empty(in_empty),
    .in_dout(in_dout), .in_rd_en(in_rd_en), .out_full(out_full), .out_wr_en(out_wr_en),
    .out_din(out_din), .box_x(box_x), .box_y(box_y), .box_w(box_w), .box_h(box_h),
    .box_found(box_found), .box_valid(box_valid));

  box_locator #(.IMG_W(8), .IMG_H(6), .R_MIN(8'd96), .MIN_PIXELS(19'd1)) dut1 (
    .clock(clk), .reset(reset), .frame_sync(frame_sync), .in_empty(in_empty),
    .in_dout(in_dout), .in_rd_en(in_rd_en1), .out_full(out_full), .out_wr_en(out_wr_en1),
    .out_din(out_din1), .box_x(box_x1), .box_y(box_y1), .box_w(box_w1), .box_h(box_h1),
    .box_found(box_found1), .box_valid(box_valid1));

  vec_t        tbl[7];
  logic [23:0] frm[48];
  logic [23:0] pq[$];
  exp_t        bq[$];
  exp_t        last, e;
  int          asserts = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    asserts++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, a, x, $time);
    end
  endtask

  task automatic cmp_box(input exp_t x);
    chk("box_x", 32'(box_x), 32'(x.x));
    chk("box_y", 32'(box_y), 32'(x.y));
    chk("box_w", 32'(box_w), 32'(x.w));
    chk("box_h", 32'(box_h), 32'(x.h));
    chk("box_found", 32'(box_found), 32'(x.f));
    chk("box_x_min1", 32'(box_x1), 32'(x.x1));
    chk("box_y_min1", 32'(box_y1), 32'(x.y1));
    chk("box_w_min1", 32'(box_w1), 32'(x.w1));
    chk("box_h_min1", 32'(box_h1), 32'(x.h1));
    chk("box_found_min1", 32'(box_found1), 32'(x.f1));
  endtask

  always @(negedge clk) begin
    if (out_full || in_empty || !reset)
      chk("no_xfer", 32'({in_rd_en, out_wr_en}), 32'd0);
    else
      chk("xfer", 32'({in_rd_en, out_wr_en}), 32'd3);
    if (out_wr_en) begin
      chk("pixel_expected", 32'(pq.size() != 0), 32'd1);
      if (pq.size() != 0) chk("out_din", 32'(out_din), 32'(pq.pop_front()));
    end
    if (box_valid || box_valid1) begin
      chk("valid_pair", 32'({box_valid, box_valid1}), 32'd3);
      chk("box_expected", 32'(bq.size() != 0), 32'd1);
      if (bq.size() != 0) cmp_box(bq.pop_front());
    end
  end

  task automatic load(input vec_t v);
    for (int k = 0; k < 48; k++) frm[k] = v.m[k] ? v.c : 24'h0;
  endtask

  // Drives frm[first..first+count-1]; sync0 raises frame_sync with the first pixel.
  task automatic run(input int first, input int count, input bit sync0, input bit stall);
    int i = first;
    int fullc = 0;
    while (i < first + count) begin
      @(posedge clk); #1;
      in_empty = stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      out_full = stall && i == first + 20 && fullc < 5;
      if (out_full) fullc++;
      in_dout = in_empty ? 24'($urandom) : frm[i];
      frame_sync = sync0 && i == first && !in_empty && !out_full;
      if (!in_empty && !out_full) begin
        pq.push_back(frm[i]);
        i++;
      end
    end
    @(posedge clk); #1;
    in_empty = 1'b1;
    out_full = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("box_pending", 32'(bq.size()), 32'd0);
    cmp_box(last);
  endtask

  initial begin
    tbl[0] = '{24'h000000, 48'h0, '0};
    tbl[1] = '{24'hC02020, 48'h0000_2400_2400,
               '{10'd2, 10'd1, 10'd4, 10'd3, 1'b1, 10'd2, 10'd1, 10'd4, 10'd3, 1'b1}};
    tbl[2] = '{24'hFF0000, 48'h8000_0000_0000,
               '{10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 10'd7, 10'd5, 10'd1, 10'd1, 1'b1}};
    tbl[3] = '{24'h606060, 48'h0010_0008_0000, '0};
    tbl[4] = '{24'h5FFF00, 48'h4000_0000_0200, '0};
    tbl[5] = '{24'h600000, 48'h8000_0000_0001,
               '{10'd0, 10'd0, 10'd8, 10'd6, 1'b1, 10'd0, 10'd0, 10'd8, 10'd6, 1'b1}};
    tbl[6] = '{24'h600000, 48'h0000_0008_0000,
               '{10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 10'd3, 10'd2, 10'd1, 10'd1, 1'b1}};

    // reset with a pixel available: nothing may be popped
    reset = 1'b0;
    in_empty = 1'b0;
    in_dout = 24'hFF0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp_box('0);
    chk("valid_in_reset", 32'(box_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    in_empty = 1'b1;
    last = '0;

    for (int i = 0; i < 7; i++) begin
      load(tbl[i]);
      bq.push_back(tbl[i].e);
      last = tbl[i].e;
      run(0, 48, 1'b0, 1'b0);
      settle();
    end

    // backpressure: random empties plus 5 cycles of full at pixel 20
    load(tbl[1]);
    bq.push_back(tbl[1].e);
    last = tbl[1].e;
    run(0, 48, 1'b0, 1'b1);
    settle();

    // frame_sync at pixel 20; earlier match at (7,1) must be discarded
    for (int k = 0; k < 48; k++) frm[k] = k == 15 ? 24'hFF0000 : 24'h0;
    run(0, 20, 1'b0, 1'b0);
    for (int k = 0; k < 48; k++) frm[k] = (k == 0 || k == 10) ? 24'hC02020 : 24'h0;
    e = '{10'd0, 10'd0, 10'd3, 10'd2, 1'b1, 10'd0, 10'd0, 10'd3, 10'd2, 1'b1};
    bq.push_back(e);
    last = e;
    run(0, 1, 1'b1, 1'b0);
    chk("col_after_sync", 32'(dut.col_q), 32'd1);
    chk("row_after_sync", 32'(dut.row_q), 32'd0);
    chk("no_valid_on_sync", 32'(box_valid), 32'd0);
    run(1, 47, 1'b0, 1'b0);
    settle();

    // frame_sync on the eof pixel: no report, that pixel becomes (0,0)
    for (int k = 0; k < 48; k++) frm[k] = k == 47 ? 24'h600000 : 24'h0;
    e = '{10'd0, 10'd0, 10'd8, 10'd6, 1'b1, 10'd0, 10'd0, 10'd8, 10'd6, 1'b1};
    bq.push_back(e);
    last = e;
    run(0, 47, 1'b0, 1'b0);
    run(47, 1, 1'b1, 1'b0);
    run(1, 47, 1'b0, 1'b0);
    settle();

    // reset for one cycle at pixel 30
    load(tbl[1]);
    run(0, 30, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    in_empty = 1'b0;
    in_dout = frm[30];
    @(negedge clk);
    chk("rd_en_in_reset", 32'(in_rd_en), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    in_empty = 1'b1;
    @(negedge clk);
    cmp_box('0);
    bq.push_back(tbl[1].e);
    last = tbl[1].e;
    run(0, 48, 1'b0, 1'b0);
    settle();

    chk("pixels_pending", 32'(pq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/box_locator.md
Name: box_locator

Overview:
- Streaming stage directly upstream of the box-drawing top.
- Pops 24-bit RGB pixels from an upstream FWFT FIFO and pushes them unchanged into the box-drawing input FIFO.
- While passing pixels through, scans each frame for skin-coloured pixels and tracks their bounding rectangle.
- At end of frame, latches x/y/width/height, which drive the box-drawing x,y,width,height inputs for the next frame.

Parameters:
IMG_W, 640, pixels per line (1..1023)
IMG_H, 480, lines per frame (1..1023)
R_MIN, 96, minimum red value for a match (8-bit)
MIN_PIXELS, 64, matched-pixel count required to report a box (19-bit)

Ports:
clock  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
frame_sync  in  1  1-cycle pulse, restarts frame position and clears accumulators
in_empty  in  1  upstream FIFO empty
in_dout  in  24  upstream FIFO head word (FWFT): [23:16]=R, [15:8]=G, [7:0]=B
in_rd_en  out  1  pop upstream FIFO
out_full  in  1  downstream FIFO full
out_wr_en  out  1  push downstream FIFO
out_din  out  24  pixel to downstream FIFO
box_x  out  10  left column of last reported box
box_y  out  10  top row of last reported box
box_w  out  10  width of last reported box
box_h  out  10  height of last reported box
box_found  out  1  last completed frame met MIN_PIXELS
box_valid  out  1  1-cycle pulse when box_* update

Behaviour:
- Transfer:
  - xfer = !in_empty && !out_full.
  - in_rd_en = out_wr_en = xfer, combinational.
  - out_din = in_dout. Zero latency, no storage; pixel data is never altered.
- Match rule: match = xfer && R >= R_MIN && R > G && R > B, all unsigned 8-bit compares.
- Position counters col (10b) and row (10b), reset to 0.
  - On xfer, col increments.
  - At col == IMG_W-1, col wraps to 0 and row increments.
  - At col == IMG_W-1 and row == IMG_H-1, both wrap to 0 (end of frame, eof).
- Accumulators:
  - min_x/min_y reset to 1023; max_x/max_y reset to 0; hit_cnt (19b, saturating) resets to 0.
  - On match: min_x = min(min_x, col), max_x = max(max_x, col), likewise for y with row; hit_cnt += 1.
- End of frame: on the eof transfer cycle, the result includes that last pixel's match (use next-state values). At the following edge:
  - If final hit_cnt >= MIN_PIXELS:
    - box_x = min_x, box_y = min_y.
    - box_w = max_x - min_x + 1, box_h = max_y - min_y + 1, 10-bit unsigned.
    - box_found = 1.
  - Otherwise: box_x = box_y = box_w = box_h = 0 and box_found = 0.
  - box_valid = 1 for exactly one cycle.
  - Accumulators return to their reset values at the same edge.
- Between eof events, box_* and box_found hold steady. Downstream samples them continuously.
- frame_sync:
  - Clears col, row and all accumulators; produces no box_valid; box_* unchanged.
  - If xfer occurs in the same cycle, that pixel is counted as (0,0) of the new frame: col = 1, row = 0 afterwards, and the accumulators hold just that pixel's match.
  - frame_sync on the eof cycle takes priority: no report, and the pixel becomes (0,0).
- Stalls (in_empty or out_full) freeze counters and accumulators. No gaps or skips are introduced.
- Reset (reset == 0):
  - Same edge: box_x/y/w/h = 0, box_found = 0, box_valid = 0; counters and accumulators to reset values.
  - in_rd_en/out_wr_en remain combinational and are forced to 0 while reset is low.
  - Reset mid-frame discards the partial frame.
- No explicit FSM beyond the counters; a frame is either in progress or reporting on the eof edge.

Test Plan:
- Bench params IMG_W=8, IMG_H=6, R_MIN=96, MIN_PIXELS=2.
  - Stimulus: all-black frame, then 4 pixels 0xC02020 at (2,1),(5,1),(2,3),(5,3).
  - Required: 1st eof gives box_found=0, all box_*=0. 2nd eof gives box_x=2, box_y=1, box_w=4, box_h=3, box_found=1, with exactly one box_valid pulse per frame.
- Single match 0xFF0000 at (7,5), the last pixel, MIN_PIXELS=1 -> box_x=7, box_y=5, box_w=1, box_h=1. Confirms eof inclusion.
- Pixel 0x606060 (R == G) and 0x5FFF00 -> no match, hit_cnt unchanged. Pixel 0x600000 (R == R_MIN) -> match.
- Backpressure:
  - Hold out_full=1 for 5 cycles mid-frame, with random in_empty gaps.
  - Required: no in_rd_en/out_wr_en while full; output sequence equals input sequence; box results identical to the unstalled run.
- Control events:
  - frame_sync at pixel 20 with a simultaneous xfer -> col=1, row=0 next cycle, no box_valid.
  - reset low for 1 cycle at pixel 30 -> all box outputs 0, next frame reported correctly.
